// File: rtl/aes_host_pkg.sv
// Shared constants, frame layout and state encoding for the AES SPI host sequencer.
package aes_host_pkg;

  localparam int FRAME_W     = 392;
  localparam int TIMEOUT_CYC = 4096;
  localparam int ENC_XFERS   = 3;
  localparam int DEC_XFERS   = 4;
  localparam int TMO_W       = $clog2(TIMEOUT_CYC);

  localparam logic [7:0] KS_128 = 8'd16;
  localparam logic [7:0] KS_192 = 8'd24;
  localparam logic [7:0] KS_256 = 8'd32;

  // Frame field offsets: {text[127:0], key_size[7:0], key[255:0]}
  localparam int TEXT_MSB = 391;
  localparam int KSZ_MSB  = 263;
  localparam int KEY_MSB  = 255;
  // Response fields inside the frame returned by the master
  localparam int RES_MSB  = 383;
  localparam int ECHO_MSB = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_XFER   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  function automatic logic key_size_ok(input logic [7:0] ks);
    return (ks == KS_128) || (ks == KS_192) || (ks == KS_256);
  endfunction

endpackage

// File: rtl/aes_spi_host_seq.sv
// Host-side sequencer: takes one AES job, builds the SPI frame, runs the fixed
// send/wait/receive transaction sequence on the SPI master and returns the result.
module aes_spi_host_seq
  import aes_host_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_decrypt,
  input  logic [127:0]        req_text,
  input  logic [7:0]          req_key_size,
  input  logic [255:0]        req_key,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [127:0]        rsp_data,
  output logic                rsp_echo_ok,
  output logic                rsp_error,
  output logic                spi_start,
  input  logic                spi_busy,
  input  logic                spi_done,
  output logic [FRAME_W-1:0]  spi_data_in,
  input  logic [FRAME_W-1:0]  spi_data_out
);

  state_e             state_q, state_d;
  logic [2:0]         xfer_cnt_q, xfer_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               dec_q, dec_d;
  logic [127:0]       text_q, text_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [127:0]       rsp_data_q, rsp_data_d;
  logic               rsp_echo_q, rsp_echo_d;
  logic               rsp_error_q, rsp_error_d;

  logic               accept;
  logic               last_xfer;
  logic               tmo_hit;
  logic [2:0]         xfer_target;
  logic [127:0]       res_field;
  logic [127:0]       echo_field;
  logic               unused_frame_bits;

  assign accept      = req_valid && (state_q == ST_IDLE);
  assign xfer_target = dec_q ? 3'(DEC_XFERS) : 3'(ENC_XFERS);
  assign last_xfer   = (xfer_cnt_q + 3'd1) == xfer_target;
  // Terminal count lands on the TIMEOUT_CYC-th cycle after spi_start, so a
  // done in that same cycle is still inside the allowed window.
  assign tmo_hit     = tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1);
  assign res_field   = spi_data_out[RES_MSB -: 128];
  assign echo_field  = spi_data_out[ECHO_MSB -: 128];
  assign unused_frame_bits = ^{spi_data_out[FRAME_W-1:RES_MSB+1],
                               spi_data_out[ECHO_MSB-128:0]};

  // State and datapath registers; reset clears everything including the frame
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      xfer_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      dec_q       <= 1'b0;
      text_q      <= '0;
      frame_q     <= '0;
      rsp_data_q  <= '0;
      rsp_echo_q  <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      xfer_cnt_q  <= xfer_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      dec_q       <= dec_d;
      text_q      <= text_d;
      frame_q     <= frame_d;
      rsp_data_q  <= rsp_data_d;
      rsp_echo_q  <= rsp_echo_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Next-state logic: job accept, launch gating on busy, done/timeout exits
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = key_size_ok(req_key_size) ? ST_LAUNCH : ST_RESP;
      ST_LAUNCH: if (!spi_busy) state_d = ST_XFER;
      ST_XFER: begin
        if (spi_done)     state_d = last_xfer ? ST_RESP : ST_LAUNCH;
        else if (tmo_hit) state_d = ST_RESP;
      end
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath updates: frame latch, transaction/timeout counting, result capture
  always_comb begin
    xfer_cnt_d  = xfer_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    dec_d       = dec_q;
    text_d      = text_q;
    frame_d     = frame_q;
    rsp_data_d  = rsp_data_q;
    rsp_echo_d  = rsp_echo_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          frame_d[TEXT_MSB -: 128] = req_text;
          frame_d[KSZ_MSB  -: 8]   = req_key_size;
          frame_d[KEY_MSB  -: 256] = req_key;
          dec_d       = req_decrypt;
          text_d      = req_text;
          xfer_cnt_d  = '0;
          rsp_data_d  = '0;
          rsp_echo_d  = 1'b0;
          rsp_error_d = !key_size_ok(req_key_size);
        end
      end
      ST_LAUNCH: tmo_cnt_d = '0;
      ST_XFER: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (spi_done) begin
          xfer_cnt_d = xfer_cnt_q + 3'd1;
          if (last_xfer) begin
            rsp_data_d  = res_field;
            rsp_echo_d  = dec_q ? 1'b1 : (echo_field == text_q);
            rsp_error_d = 1'b0;
          end
        end else if (tmo_hit) begin
          rsp_data_d  = '0;
          rsp_echo_d  = 1'b0;
          rsp_error_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Handshake and launch outputs decoded from the current state
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    spi_start = 1'b0;
    case (state_q)
      ST_IDLE:   req_ready = 1'b1;
      ST_LAUNCH: spi_start = !spi_busy;
      ST_RESP:   rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_data    = rsp_data_q;
  assign rsp_echo_ok = rsp_echo_q;
  assign rsp_error   = rsp_error_q;
  assign spi_data_in = frame_q;

endmodule

// File: tb/tb_aes_spi_host_seq.sv
// Testbench for aes_spi_host_seq: a behavioural SPI master stub plus a job-level
// reference model (transaction counts, latency sum, result/echo/error rules).
module tb_aes_spi_host_seq;
  import aes_host_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               req_valid, req_ready, req_decrypt;
  logic [127:0]       req_text;
  logic [7:0]         req_key_size;
  logic [255:0]       req_key;
  logic               rsp_valid, rsp_ready;
  logic [127:0]       rsp_data;
  logic               rsp_echo_ok, rsp_error;
  logic               spi_start, spi_busy, spi_done;
  logic [FRAME_W-1:0] spi_data_in, spi_data_out;

  aes_spi_host_seq dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_decrypt(req_decrypt),
    .req_text(req_text), .req_key_size(req_key_size), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_echo_ok(rsp_echo_ok), .rsp_error(rsp_error),
    .spi_start(spi_start), .spi_busy(spi_busy), .spi_done(spi_done),
    .spi_data_in(spi_data_in), .spi_data_out(spi_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-transaction stimulus consumed by the master stub (lat<0 = never done)
  int                 lat_q[$];
  int                 tail_q[$];
  logic [FRAME_W-1:0] frm_q[$];
  int                 start_cnt = 0;
  bit                 abort_req = 0;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};

  task automatic check(input string tag, input logic [FRAME_W-1:0] obs, input logic [FRAME_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FRAME_W-1:0] rnd_frame();
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int i = 0; i < 12; i++) f[i*32 +: 32] = $urandom();
    f[391:384] = 8'($urandom_range(0, 255));
    return f;
  endfunction

  // Master stub: busy while running, done T cycles after start, optional busy tail
  initial begin : stub
    int rem, hold, cur_tail, t;
    rem = 0; hold = 0; cur_tail = 0;
    spi_done = 1'b0; spi_busy = 1'b0; spi_data_out = '0;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (reset || abort_req) begin
        rem = 0; hold = 0; spi_busy = 1'b0; abort_req = 0;
      end else if (rem > 0) begin
        spi_busy = 1'b1;
        rem--;
        if (rem == 0) begin
          spi_done = 1'b1;
          spi_data_out = (frm_q.size() > 0) ? frm_q.pop_front() : '0;
          hold = cur_tail;
        end
      end else if (hold > 0) begin
        spi_busy = 1'b1;
        hold--;
      end else begin
        spi_busy = 1'b0;
      end
      #1;
      if (!reset && spi_start) begin
        if (rem > 0 || spi_done) begin
          n_fail++;
          $error("FAIL start_protocol observed=start_while_active expected=idle_master cyc=%0d", cyc);
        end
        start_cnt++;
        if (lat_q.size() == 0) begin
          n_fail++;
          $error("FAIL unexpected_start observed=start expected=none cyc=%0d", cyc);
          rem = 5; cur_tail = 0;
        end else begin
          t = lat_q.pop_front();
          cur_tail = tail_q.pop_front();
          rem = (t < 0) ? 100000000 : t;
        end
      end
    end
  end

  initial begin : watchdog
    #(600000 * 10);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Push n random transactions; the last one carries no busy tail
  task automatic push_rand(input int n, input logic [127:0] text);
    logic [FRAME_W-1:0] f;
    for (int i = 0; i < n; i++) begin
      lat_q.push_back($urandom_range(1, 12));
      tail_q.push_back((i == n - 1) ? 0 : $urandom_range(0, 3));
      f = rnd_frame();
      if ($urandom_range(0, 1) == 1) f[255:128] = text;
      frm_q.push_back(f);
    end
  endtask

  // One job end to end, checked against the job-level model
  task automatic run_job(input bit dec, input logic [127:0] text, input logic [7:0] ksz,
                         input logic [255:0] key, input int hold, input string tag);
    bit bad, tmo, ready_low, stable;
    int n, lat, exp_starts, s0, a, waited;
    logic [127:0] exp_data, snap;
    logic exp_echo;
    bad = !(ksz == 8'd16 || ksz == 8'd24 || ksz == 8'd32);
    n   = bad ? 0 : (dec ? 4 : 3);
    tmo = 0; lat = 1; exp_starts = n;
    for (int i = 0; i < n; i++) begin
      if (lat_q[i] < 0) begin
        tmo = 1; lat += 1 + TIMEOUT_CYC; exp_starts = i + 1;
        break;
      end
      lat += 1 + lat_q[i] + ((i < n - 1) ? tail_q[i] : 0);
    end
    exp_data = (bad || tmo) ? 128'h0 : frm_q[n-1][383:256];
    exp_echo = (bad || tmo) ? 1'b0 : (dec ? 1'b1 : (frm_q[n-1][255:128] == text));

    s0 = start_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_decrypt = dec; req_text = text;
    req_key_size = ksz; req_key = key;
    a = cyc;
    check({tag, "_req_ready_idle"}, req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_text = rnd_frame()[127:0];
    if (!bad) check({tag, "_frame"}, spi_data_in, {text, ksz, key});
    ready_low = 1; waited = 0;
    while (!rsp_valid && waited < 3 * TIMEOUT_CYC + 200) begin
      if (req_ready) ready_low = 0;
      @(posedge clk); #1;
      waited++;
    end
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_latency"}, cyc - a, lat);
    check({tag, "_req_ready_low"}, ready_low, 1);
    check({tag, "_rsp_data"}, rsp_data, exp_data);
    check({tag, "_rsp_error"}, rsp_error, bad || tmo);
    if (!(bad || tmo)) check({tag, "_echo"}, rsp_echo_ok, exp_echo);
    check({tag, "_starts"}, start_cnt - s0, exp_starts);
    snap = rsp_data; stable = 1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_data !== snap || req_ready) stable = 0;
    end
    if (hold > 0) check({tag, "_hold_stable"}, stable, 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_rsp_valid_drop"}, rsp_valid, 0);
    check({tag, "_req_ready_back"}, req_ready, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_echo"}, rsp_echo_ok, 0);
    check({tag, "_error"}, rsp_error, 0);
    check({tag, "_spi_start"}, spi_start, 0);
    check({tag, "_spi_data_in"}, spi_data_in, 0);
  endtask

  initial begin : main
    logic [FRAME_W-1:0] f;
    bit dec;
    logic [7:0] ksz;
    logic [127:0] txt;
    int s0, waited;
    reset = 1'b1; req_valid = 1'b0; req_decrypt = 1'b0; req_text = '0;
    req_key_size = '0; req_key = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    // Encrypt AES-192 known vector, response held off for 10 cycles
    f = '0; f[383:256] = CT; f[255:128] = PT;
    lat_q = '{5, 3, 7}; tail_q = '{0, 2, 0}; frm_q = '{f, f, f};
    run_job(1'b0, PT, 8'd24, K192, 10, "enc192");
    check("enc192_known_ct", rsp_data, CT);

    // Decrypt AES-192 known vector
    f = rnd_frame(); f[383:256] = PT;
    lat_q = '{4, 2, 6, 3}; tail_q = '{1, 0, 2, 0}; frm_q = '{f, f, f, f};
    run_job(1'b1, CT, 8'd24, K192, 0, "dec192");
    check("dec192_known_pt", rsp_data, PT);

    // Illegal key size: immediate error, no SPI traffic
    run_job(1'b0, PT, 8'd20, K192, 1, "badksz");

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      dec = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: ksz = 8'd16;
        1: ksz = 8'd24;
        2: ksz = 8'd32;
        default: ksz = 8'($urandom_range(0, 255));
      endcase
      txt = rnd_frame()[127:0];
      if (ksz == 8'd16 || ksz == 8'd24 || ksz == 8'd32) push_rand(dec ? 4 : 3, txt);
      run_job(dec, txt, ksz, {rnd_frame()[255:0]}, $urandom_range(0, 3), $sformatf("rnd%0d", j));
    end

    // Master never finishes: timeout error, then a normal job
    lat_q = '{-1}; tail_q = '{0}; frm_q = '{rnd_frame()};
    run_job(1'b0, PT, 8'd16, K192, 0, "timeout");
    abort_req = 1;
    lat_q.delete(); tail_q.delete(); frm_q.delete();
    @(posedge clk); @(posedge clk);
    push_rand(3, PT);
    run_job(1'b0, PT, 8'd32, K192, 0, "after_tmo");

    // Done arrives on the timeout terminal-count cycle: result still valid
    f = rnd_frame(); f[255:128] = PT;
    lat_q = '{TIMEOUT_CYC, 2, 3}; tail_q = '{0, 0, 0}; frm_q = '{rnd_frame(), rnd_frame(), f};
    run_job(1'b0, PT, 8'd16, K192, 0, "done_at_tc");

    // Reset during the second transaction drops the job
    lat_q = '{6, 20, 6}; tail_q = '{0, 0, 0}; frm_q = '{rnd_frame(), rnd_frame(), rnd_frame()};
    s0 = start_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_decrypt = 1'b0; req_text = PT; req_key_size = 8'd24; req_key = K192;
    @(posedge clk); #1;
    req_valid = 1'b0;
    waited = 0;
    while (start_cnt < s0 + 2 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check("midreset_second_start", start_cnt - s0, 2);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_values("midreset");
    reset = 1'b0;
    lat_q.delete(); tail_q.delete(); frm_q.delete();
    repeat (5) @(posedge clk);
    #1;
    check("midreset_no_rsp", rsp_valid, 0);

    f = '0; f[383:256] = CT; f[255:128] = PT;
    lat_q = '{3, 4, 2}; tail_q = '{0, 0, 0}; frm_q = '{f, f, f};
    run_job(1'b0, PT, 8'd24, K192, 0, "post_reset");
    check("post_reset_known_ct", rsp_data, CT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
